// File: rtl/ahb_manager_arbiter.sv
// ahb_manager_arbiter: shares one AHB manager port between NUM_MGR managers using
// round-robin arbitration at burst boundaries, grant parking and one-entry address buffers.
package ahb_pkg;
    localparam int AHB_AW = 32;
    localparam int AHB_DW = 32;
    localparam int AHB_NM = 4;
    typedef enum logic [1:0] {Idle = 2'd0, Busy = 2'd1, NonSeq = 2'd2, Seq = 2'd3} htrans_e;
    typedef enum logic [2:0] {Single, Incr, Wrap4, Incr4, Wrap8, Incr8, Wrap16, Incr16} hburst_e;
    typedef enum logic {Okay = 1'b0, Error = 1'b1} hresp_e;
    typedef struct packed {
        logic [AHB_AW-1:0]   h_address;
        htrans_e             h_trans;
        logic                h_write;
        logic [2:0]          h_size;
        hburst_e             h_burst;
        logic [3:0]          h_prot;
        logic [AHB_NM-1:0]   h_master;
        logic                h_mastlock;
        logic                h_nonsec;
        logic                h_excl;
        logic [AHB_DW-1:0]   h_wdata;
        logic [AHB_DW/8-1:0] h_wstrb;
    } h_manager_out_t;
    typedef struct packed {
        logic              h_ready;
        hresp_e            h_resp;
        logic              h_exokay;
        logic [AHB_DW-1:0] h_rdata;
    } h_manager_in_t;
    localparam h_manager_out_t AHB_MANAGER_OUT_DEFAULT = '{
        h_address: '0, h_trans: Idle, h_write: 1'b0, h_size: 3'd0, h_burst: Single,
        h_prot: 4'b0011, h_master: '0, h_mastlock: 1'b0, h_nonsec: 1'b0, h_excl: 1'b0,
        h_wdata: '0, h_wstrb: '0};
endpackage

module ahb_manager_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MGR = 2,
    localparam int IDX_W = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  h_manager_out_t mgr_req_i [NUM_MGR],
    output h_manager_in_t  mgr_rsp_o [NUM_MGR],
    output h_manager_out_t sub_req_o,
    input  h_manager_in_t  sub_rsp_i
);
    logic [IDX_W-1:0]   grant_q, grant_d, data_q, data_d, idx;
    logic               data_vld_q, data_vld_d, incr_q, incr_d, lock_q, lock_d, found;
    logic [3:0]         beats_q, beats_d;
    logic [NUM_MGR-1:0] pend_vld_q, pend_vld_d, act, own, cap;
    h_manager_out_t     pend_q [NUM_MGR];
    h_manager_out_t     pend_d [NUM_MGR];
    h_manager_out_t     eff [NUM_MGR];
    h_manager_out_t     gnt;

    always_comb begin
        for (int i = 0; i < NUM_MGR; i++) begin
            eff[i] = pend_vld_q[i] ? pend_q[i] : mgr_req_i[i];
            act[i] = eff[i].h_trans inside {NonSeq, Seq};
        end
        gnt = eff[grant_q];
    end

    always_comb begin
        sub_req_o          = gnt;
        sub_req_o.h_master = AHB_NM'(grant_q);
        sub_req_o.h_wdata  = data_vld_q ? mgr_req_i[data_q].h_wdata : '0;
        sub_req_o.h_wstrb  = data_vld_q ? mgr_req_i[data_q].h_wstrb : '0;
        if (rst_i) sub_req_o = AHB_MANAGER_OUT_DEFAULT;
    end

    // A manager that is neither data owner nor buffered sees a zero-wait address phase.
    always_comb begin
        for (int i = 0; i < NUM_MGR; i++) begin
            own[i]                = data_vld_q && data_q == IDX_W'(i);
            mgr_rsp_o[i].h_rdata  = rst_i ? '0 : sub_rsp_i.h_rdata;
            mgr_rsp_o[i].h_ready  = own[i] ? sub_rsp_i.h_ready : !pend_vld_q[i];
            mgr_rsp_o[i].h_resp   = own[i] ? sub_rsp_i.h_resp : Okay;
            mgr_rsp_o[i].h_exokay = own[i] && sub_rsp_i.h_exokay;
            cap[i] = mgr_rsp_o[i].h_ready && !pend_vld_q[i]
                && mgr_req_i[i].h_trans inside {NonSeq, Seq}
                && !(grant_q == IDX_W'(i) && sub_rsp_i.h_ready);
        end
    end

    always_comb begin
        grant_d    = grant_q;
        data_d     = data_q;
        data_vld_d = data_vld_q;
        beats_d    = beats_q;
        incr_d     = incr_q;
        lock_d     = lock_q;
        found      = 1'b0;
        idx        = grant_q;
        for (int i = 0; i < NUM_MGR; i++) begin
            pend_vld_d[i] = (grant_q == IDX_W'(i) && sub_rsp_i.h_ready) ? 1'b0 : (cap[i] || pend_vld_q[i]);
            pend_d[i]     = cap[i] ? mgr_req_i[i] : pend_q[i];
        end
        if (sub_rsp_i.h_ready) begin
            data_vld_d = act[grant_q];
            data_d     = grant_q;
            if (gnt.h_trans == NonSeq) begin
                beats_d = gnt.h_burst inside {Wrap16, Incr16} ? 4'd15 :
                          gnt.h_burst inside {Wrap8, Incr8}   ? 4'd7  :
                          gnt.h_burst inside {Wrap4, Incr4}   ? 4'd3  : 4'd0;
                incr_d  = gnt.h_burst == Incr;
            end else if (gnt.h_trans == Seq) begin
                beats_d = (beats_q == 4'd0) ? 4'd0 : beats_q - 4'd1;
            end else if (gnt.h_trans == Idle) begin
                incr_d = 1'b0;
            end
            lock_d = gnt.h_mastlock;
            // Rotate from grant_q+1 and visit grant_q last; no requester leaves the grant parked.
            if (beats_d == 4'd0 && !incr_d && !lock_d) begin
                for (int k = 1; k <= NUM_MGR; k++) begin
                    idx = IDX_W'((int'(grant_q) + k) % NUM_MGR);
                    if (!found && act[idx]) begin
                        grant_d = idx;
                        found   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q    <= '0;
            data_q     <= '0;
            data_vld_q <= 1'b0;
            beats_q    <= '0;
            incr_q     <= 1'b0;
            lock_q     <= 1'b0;
            pend_vld_q <= '0;
            for (int i = 0; i < NUM_MGR; i++) pend_q[i] <= AHB_MANAGER_OUT_DEFAULT;
        end else begin
            grant_q    <= grant_d;
            data_q     <= data_d;
            data_vld_q <= data_vld_d;
            beats_q    <= beats_d;
            incr_q     <= incr_d;
            lock_q     <= lock_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
        end
    end
endmodule

// File: tb/tb_ahb_manager_arbiter.sv
// tb_ahb_manager_arbiter: directed two-manager scenarios; forwarded address phases and
// their data phases are checked against an expected-transfer scoreboard.
module tb_ahb_manager_arbiter;
    import ahb_pkg::*;

    typedef struct packed {
        htrans_e     t;
        hburst_e     b;
        logic        l;
        logic [31:0] a;
    } item_t;
    typedef struct packed {
        logic [31:0] m;
        logic [31:0] a;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    h_manager_out_t mgr_req [2];
    h_manager_in_t  mgr_rsp [2];
    h_manager_out_t sub_req;
    h_manager_in_t  sub_rsp;
    item_t          mq0[$];
    item_t          mq1[$];
    exp_t           exp_q[$];
    int             checks = 0;
    int             errors = 0;
    logic           dp_v = 1'b0;
    int             dp_m = 0;
    logic [1:0]     rdy;

    always #5 clk = ~clk;

    ahb_manager_arbiter #(.NUM_MGR(2)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .mgr_req_i (mgr_req),
        .mgr_rsp_o (mgr_rsp),
        .sub_req_o (sub_req),
        .sub_rsp_i (sub_rsp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] wd(input int m);
        return 32'hD000_0000 + 32'(m + 1) * 32'h1111;
    endfunction

    function automatic item_t it(input htrans_e tr, input hburst_e bu, input logic lk, input logic [31:0] ad);
        return '{t: tr, b: bu, l: lk, a: ad};
    endfunction

    function automatic h_manager_out_t req_of(input item_t x, input int m);
        h_manager_out_t r = AHB_MANAGER_OUT_DEFAULT;
        r.h_trans    = x.t;
        r.h_burst    = x.b;
        r.h_mastlock = x.l;
        r.h_address  = x.a;
        r.h_write    = 1'b1;
        r.h_size     = 3'd2;
        r.h_wdata    = wd(m);
        r.h_wstrb    = 4'hF;
        return r;
    endfunction

    task automatic expect_xfer(input int m, input logic [31:0] a);
        exp_q.push_back('{m: 32'(m), a: a});
    endtask

    // Drive one cycle of stimulus at the falling edge, then score what the DUT forwards.
    task automatic drv(input logic r, input logic e);
        item_t idle = it(Idle, Single, 1'b0, 32'h0);
        logic  acc;
        exp_t  x;
        mgr_req[0] = req_of(mq0.size() > 0 ? mq0[0] : idle, 0);
        mgr_req[1] = req_of(mq1.size() > 0 ? mq1[0] : idle, 1);
        sub_rsp.h_ready  = r;
        sub_rsp.h_resp   = e ? Error : Okay;
        sub_rsp.h_exokay = 1'b0;
        sub_rsp.h_rdata  = $urandom;
        #1;
        if (!rst_i) begin
            if (dp_v && sub_rsp.h_ready) begin
                chk("dp_wdata", sub_req.h_wdata, wd(dp_m));
                chk("dp_ready", mgr_rsp[dp_m].h_ready, 1);
            end
            acc = sub_req.h_trans inside {NonSeq, Seq} && sub_rsp.h_ready;
            if (sub_rsp.h_ready) dp_v = acc;
            if (acc) begin
                if (exp_q.size() == 0) chk("sb_unexpected", sub_req.h_address, 32'hDEAD_BEEF);
                else begin
                    x = exp_q.pop_front();
                    chk("sb_addr", sub_req.h_address, x.a);
                    chk("sb_master", sub_req.h_master, x.m);
                    dp_m = int'(x.m);
                end
            end
        end
    endtask

    task automatic adv();
        rdy[0] = mgr_rsp[0].h_ready;
        rdy[1] = mgr_rsp[1].h_ready;
        @(posedge clk);
        #1;
        if (rdy[0] && mq0.size() > 0) void'(mq0.pop_front());
        if (rdy[1] && mq1.size() > 0) void'(mq1.pop_front());
        @(negedge clk);
    endtask

    task automatic cyc(input logic r, input logic e);
        drv(r, e);
        adv();
    endtask

    initial begin
        mgr_req[0] = req_of(it(NonSeq, Single, 1'b0, 32'h100), 0);
        mgr_req[1] = req_of(it(Idle, Single, 1'b0, 32'h0), 1);
        sub_rsp = '{h_ready: 1'b1, h_resp: Okay, h_exokay: 1'b0, h_rdata: 32'h1234_5678};
        #1;
        chk("rst_sub_idle", sub_req.h_trans, Idle);
        chk("rst_rdy0", mgr_rsp[0].h_ready, 1);
        chk("rst_rdy1", mgr_rsp[1].h_ready, 1);
        chk("rst_rdata", mgr_rsp[0].h_rdata, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;

        // Parked on manager 0: zero-latency forward, stalled then completed data phase.
        mq0.push_back(it(NonSeq, Single, 1'b0, 32'h100));
        expect_xfer(0, 32'h100);
        drv(1'b1, 1'b0);
        chk("s1_addr", sub_req.h_address, 32'h100);
        chk("s1_trans", sub_req.h_trans, NonSeq);
        chk("rdata_bcast", mgr_rsp[1].h_rdata, sub_rsp.h_rdata);
        adv();
        drv(1'b0, 1'b0);
        chk("s1_stall_rdy", mgr_rsp[0].h_ready, 0);
        adv();
        drv(1'b1, 1'b0);
        chk("s1_wdata", sub_req.h_wdata, wd(0));
        adv();
        cyc(1'b1, 1'b0);

        // Contention: manager 1 is buffered and forwarded one cycle later.
        mq0.push_back(it(NonSeq, Single, 1'b0, 32'h200));
        mq1.push_back(it(NonSeq, Single, 1'b0, 32'h300));
        expect_xfer(0, 32'h200);
        expect_xfer(1, 32'h300);
        drv(1'b1, 1'b0);
        chk("s2_first_master", sub_req.h_master, 0);
        adv();
        drv(1'b1, 1'b0);
        chk("s2_second_master", sub_req.h_master, 1);
        chk("s2_pend_rdy", mgr_rsp[1].h_ready, 0);
        adv();
        drv(1'b1, 1'b0);
        chk("s2_dp_rdy", mgr_rsp[1].h_ready, 1);
        adv();
        cyc(1'b1, 1'b0);

        // Incr4 from manager 1 is not split by manager 0 requesting on beat 2.
        mq1.push_back(it(NonSeq, Incr4, 1'b0, 32'h400));
        for (int i = 1; i < 4; i++) mq1.push_back(it(Seq, Incr4, 1'b0, 32'h400 + 32'(4 * i)));
        mq0.push_back(it(Idle, Single, 1'b0, 32'h0));
        mq0.push_back(it(NonSeq, Single, 1'b0, 32'h500));
        for (int i = 0; i < 4; i++) expect_xfer(1, 32'h400 + 32'(4 * i));
        expect_xfer(0, 32'h500);
        for (int c = 1; c <= 6; c++) begin
            drv(1'b1, 1'b0);
            if (c == 3) chk("s3_wait_rdy", mgr_rsp[0].h_ready, 0);
            if (c == 5) chk("s3_regrant", sub_req.h_master, 0);
            adv();
        end

        // Three stall cycles mid-burst keep the request stable and the beat count frozen.
        mq0.push_back(it(NonSeq, Incr4, 1'b0, 32'h600));
        for (int i = 1; i < 4; i++) mq0.push_back(it(Seq, Incr4, 1'b0, 32'h600 + 32'(4 * i)));
        mq1.push_back(it(Idle, Single, 1'b0, 32'h0));
        mq1.push_back(it(Idle, Single, 1'b0, 32'h0));
        mq1.push_back(it(NonSeq, Single, 1'b0, 32'h700));
        for (int i = 0; i < 4; i++) expect_xfer(0, 32'h600 + 32'(4 * i));
        expect_xfer(1, 32'h700);
        for (int c = 1; c <= 9; c++) begin
            drv(!(c >= 3 && c <= 5), 1'b0);
            if (c >= 3 && c <= 5) begin
                chk("s4_stall_addr", sub_req.h_address, 32'h608);
                chk("s4_stall_trans", sub_req.h_trans, Seq);
                chk("s4_stall_rdy", mgr_rsp[0].h_ready, 0);
            end
            adv();
        end

        // Locked pair of singles holds the grant until the owner drops the lock with Idle.
        mq1.push_back(it(NonSeq, Single, 1'b1, 32'h800));
        mq1.push_back(it(NonSeq, Single, 1'b1, 32'h804));
        mq1.push_back(it(Idle, Single, 1'b0, 32'h0));
        mq0.push_back(it(NonSeq, Single, 1'b0, 32'h900));
        expect_xfer(1, 32'h800);
        expect_xfer(1, 32'h804);
        expect_xfer(0, 32'h900);
        for (int c = 1; c <= 5; c++) begin
            drv(1'b1, 1'b0);
            if (c == 3) begin
                chk("s5_lock_master", sub_req.h_master, 1);
                chk("s5_lock_wait", mgr_rsp[0].h_ready, 0);
            end
            adv();
        end

        // Two-cycle ERROR on an Incr burst; the owner goes Idle and the buffered manager wins.
        mq0.push_back(it(NonSeq, Incr, 1'b0, 32'hA00));
        mq0.push_back(it(Seq, Incr, 1'b0, 32'hA04));
        mq0.push_back(it(Idle, Single, 1'b0, 32'h0));
        mq1.push_back(it(NonSeq, Single, 1'b0, 32'hB00));
        expect_xfer(0, 32'hA00);
        expect_xfer(0, 32'hA04);
        expect_xfer(1, 32'hB00);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        drv(1'b0, 1'b1);
        chk("s6_err1_resp", mgr_rsp[0].h_resp, Error);
        chk("s6_err1_rdy", mgr_rsp[0].h_ready, 0);
        chk("s6_other_rdy", mgr_rsp[1].h_ready, 0);
        adv();
        drv(1'b1, 1'b1);
        chk("s6_err2_resp", mgr_rsp[0].h_resp, Error);
        chk("s6_err2_rdy", mgr_rsp[0].h_ready, 1);
        chk("s6_other_resp", mgr_rsp[1].h_resp, Okay);
        adv();
        drv(1'b1, 1'b0);
        chk("s6_regrant", sub_req.h_master, 1);
        adv();
        cyc(1'b1, 1'b0);

        // Reset with manager 1 buffered and manager 0's data phase in flight.
        mq1.push_back(it(NonSeq, Single, 1'b0, 32'hC00));
        mq1.push_back(it(NonSeq, Single, 1'b0, 32'hC04));
        mq0.push_back(it(NonSeq, Single, 1'b0, 32'hD00));
        expect_xfer(1, 32'hC00);
        expect_xfer(0, 32'hD00);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        drv(1'b0, 1'b0);
        chk("s7_pend_rdy", mgr_rsp[1].h_ready, 0);
        chk("s7_owner_rdy", mgr_rsp[0].h_ready, 0);
        rst_i = 1'b1;
        #1;
        chk("s7_rst_rdy0", mgr_rsp[0].h_ready, 1);
        chk("s7_rst_rdy1", mgr_rsp[1].h_ready, 1);
        chk("s7_rst_idle", sub_req.h_trans, Idle);
        mq0.delete();
        mq1.delete();
        dp_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        mq1.push_back(it(NonSeq, Single, 1'b0, 32'hE00));
        expect_xfer(1, 32'hE00);
        drv(1'b1, 1'b0);
        chk("s7_post_idle", sub_req.h_trans, Idle);
        chk("s7_post_grant", sub_req.h_master, 0);
        adv();
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
